imager_frame_scheduler: RTL and testbench

IMAGER_FRAME_SCHEDULER -- requirements
Module: imager_frame_scheduler

---
 rtl/imager_frame_scheduler.sv | 221 ++++++++++++++++++++++
 tb/tb_imager_frame_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imager_frame_scheduler.sv
// imager_frame_scheduler
// Frame-level scheduler between an imager exposure FSM and the ADC readout
// sequencer. It releases frames to the exposure FSM, requests a readout for
// each exposed frame, and steps round-robin through a small table of
// per-slot exposure/pattern settings. Bursts are either counted or continuous,
// and can be aborted at the next frame boundary.
//
// Optional feature: define FRAME_SCHED_WDOG_EN to build the exposure/readout
// watchdog. Without it ERR is tied low and WDOG_LIMIT is ignored.
//
// Ports
//   CLKMPRE, RESET_B            clock (rising edge), async active-low reset
//   START, ABORT                burst control pulses
//   NUM_FRAMES                  frames per burst, 0 = continuous
//   CFG_SLOTS                   index of last active slot
//   CFG_WR_*/CFG_EXP/CFG_PAT    slot table write port
//   WDOG_LIMIT                  watchdog limit in cycles, 0 = off
//   Exp_subc, Num_Pat           registered config for the exposure FSM
//   FSMIND0/FSMIND0ACK          frame release handshake
//   FSMIND1/FSMIND1ACK          frame done / readout complete handshake
//   RO_REQ/RO_DONE              readout handshake with ADC sequencer
//   FRAME_CNT, SLOT, DONE, ERR  status; sched_stat is the one-hot state
//
// state     | meaning
// S_EXPOSE  | exposure FSM running a frame, waiting for FSMIND1
// S_READOUT | RO_REQ high, waiting for RO_DONE
// S_ACK1    | one cycle: decide end-of-burst or release the next frame
// S_RELEASE | FSMIND0 high, waiting for FSMIND0ACK
// S_HOLD    | idle between bursts, waiting for START
module imager_frame_scheduler #(
  parameter int C_EXP_SUBSC = 10,
  parameter int C_NUM_PATT  = 100,
  parameter int C_SLOT_AW   = 2
) (
  input  logic                 CLKMPRE,
  input  logic                 RESET_B,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [15:0]          NUM_FRAMES,
  input  logic [C_SLOT_AW-1:0] CFG_SLOTS,
  input  logic                 CFG_WR_EN,
  input  logic [C_SLOT_AW-1:0] CFG_WR_ADDR,
  input  logic [31:0]          CFG_EXP,
  input  logic [31:0]          CFG_PAT,
  input  logic [31:0]          WDOG_LIMIT,
  output logic [31:0]          Exp_subc,
  output logic [31:0]          Num_Pat,
  output logic                 FSMIND0,
  input  logic                 FSMIND0ACK,
  input  logic                 FSMIND1,
  output logic                 FSMIND1ACK,
  output logic                 RO_REQ,
  input  logic                 RO_DONE,
  output logic [15:0]          FRAME_CNT,
  output logic [C_SLOT_AW-1:0] SLOT,
  output logic                 DONE,
  output logic                 ERR,
  output logic [4:0]           sched_stat
);

  localparam int NSLOT = 2 ** C_SLOT_AW;

  typedef enum logic [4:0] {
    S_EXPOSE  = 5'b00001,
    S_READOUT = 5'b00010,
    S_ACK1    = 5'b00100,
    S_RELEASE = 5'b01000,
    S_HOLD    = 5'b10000
  } state_t;

  state_t state;
  logic   abort_pend;

  logic [31:0]          exp_tbl [NSLOT];
  logic [31:0]          pat_tbl [NSLOT];
  logic [C_SLOT_AW-1:0] slot_next;
  logic [C_SLOT_AW-1:0] ld_slot;
  logic [31:0]          ld_exp;
  logic [31:0]          ld_pat;

  assign sched_stat = state;

  // Slot that the next config load reads: slot 0 on START, otherwise the
  // round-robin successor. A SLOT beyond a shrunk CFG_SLOTS also wraps to 0.
  // A table write to that same slot in the load cycle is forwarded.
  always_comb begin
    slot_next = (SLOT >= CFG_SLOTS) ? '0 : SLOT + C_SLOT_AW'(1);
    ld_slot   = (state == S_HOLD) ? '0 : slot_next;
    ld_exp    = exp_tbl[ld_slot];
    ld_pat    = pat_tbl[ld_slot];
    if (CFG_WR_EN && (CFG_WR_ADDR == ld_slot)) begin
      ld_exp = CFG_EXP;
      ld_pat = CFG_PAT;
    end
  end

  always_ff @(posedge CLKMPRE or negedge RESET_B) begin
    if (!RESET_B) begin
      for (int i = 0; i < NSLOT; i++) begin
        exp_tbl[i] <= 32'(C_EXP_SUBSC);
        pat_tbl[i] <= 32'(C_NUM_PATT);
      end
    end else if (CFG_WR_EN) begin
      exp_tbl[CFG_WR_ADDR] <= CFG_EXP;
      pat_tbl[CFG_WR_ADDR] <= CFG_PAT;
    end
  end

`ifdef FRAME_SCHED_WDOG_EN
  logic [31:0] wdog;
  logic        wdog_trip;

  // wdog equals the number of completed cycles in the current timed state,
  // so the trip fires on the WDOG_LIMIT-th cycle spent there.
  assign wdog_trip = (WDOG_LIMIT != 32'd0) && (wdog >= WDOG_LIMIT - 32'd1) &&
                     ((state == S_EXPOSE) || (state == S_READOUT));

  // Cleared outside the timed states and on the EXPOSE->READOUT hop.
  always_ff @(posedge CLKMPRE or negedge RESET_B) begin
    if (!RESET_B) begin
      wdog <= '0;
    end else if (!wdog_trip && ((state == S_READOUT && !RO_DONE) ||
                                (state == S_EXPOSE && !FSMIND1))) begin
      wdog <= wdog + 32'd1;
    end else begin
      wdog <= '0;
    end
  end
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WDOG_LIMIT;
  assign ERR = 1'b0;
`endif

  always_ff @(posedge CLKMPRE or negedge RESET_B) begin
    if (!RESET_B) begin
      state      <= S_EXPOSE;
      abort_pend <= 1'b0;
      Exp_subc   <= 32'(C_EXP_SUBSC);
      Num_Pat    <= 32'(C_NUM_PATT);
      SLOT       <= '0;
      FRAME_CNT  <= '0;
      FSMIND0    <= 1'b0;
      FSMIND1ACK <= 1'b0;
      RO_REQ     <= 1'b0;
      DONE       <= 1'b0;
`ifdef FRAME_SCHED_WDOG_EN
      ERR        <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
      if (ABORT) abort_pend <= 1'b1;
`ifdef FRAME_SCHED_WDOG_EN
      if (wdog_trip) begin
        ERR        <= 1'b1;
        RO_REQ     <= 1'b0;
        FSMIND1ACK <= 1'b1;
        state      <= S_HOLD;
      end else
`endif
      case (state)
        S_EXPOSE: begin
          if (FSMIND1) begin
            RO_REQ <= 1'b1;
            state  <= S_READOUT;
          end
        end
        S_READOUT: begin
          if (RO_DONE) begin
            RO_REQ     <= 1'b0;
            FSMIND1ACK <= 1'b1;
            FRAME_CNT  <= FRAME_CNT + 16'd1;
            SLOT       <= ld_slot;
            Exp_subc   <= ld_exp;
            Num_Pat    <= ld_pat;
            state      <= S_ACK1;
          end
        end
        S_ACK1: begin
          if (abort_pend || ((NUM_FRAMES != 16'd0) && (FRAME_CNT == NUM_FRAMES))) begin
            DONE  <= 1'b1;
            state <= S_HOLD;
          end else begin
            FSMIND0 <= 1'b1;
            state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (FSMIND0ACK) begin
            FSMIND0    <= 1'b0;
            FSMIND1ACK <= 1'b0;
            state      <= S_EXPOSE;
          end
        end
        S_HOLD: begin
          FSMIND1ACK <= 1'b1;
          FSMIND0    <= 1'b0;
          if (START) begin
            FRAME_CNT  <= '0;
            SLOT       <= '0;
            Exp_subc   <= ld_exp;
            Num_Pat    <= ld_pat;
            abort_pend <= 1'b0;
`ifdef FRAME_SCHED_WDOG_EN
            ERR        <= 1'b0;
`endif
            FSMIND0    <= 1'b1;
            state      <= S_RELEASE;
          end
        end
        default: begin
          RO_REQ     <= 1'b0;
          FSMIND0    <= 1'b0;
          FSMIND1ACK <= 1'b1;
          state      <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imager_frame_scheduler.sv
module tb_imager_frame_scheduler;

  localparam logic [4:0] ST_EXPOSE  = 5'b00001;
  localparam logic [4:0] ST_READOUT = 5'b00010;
  localparam logic [4:0] ST_ACK1    = 5'b00100;
  localparam logic [4:0] ST_RELEASE = 5'b01000;
  localparam logic [4:0] ST_HOLD    = 5'b10000;

  logic        CLKMPRE = 1'b0;
  logic        RESET_B = 1'b0;
  logic        START = 1'b0, ABORT = 1'b0;
  logic [15:0] NUM_FRAMES = '0;
  logic [1:0]  CFG_SLOTS = '0;
  logic        CFG_WR_EN = 1'b0;
  logic [1:0]  CFG_WR_ADDR = '0;
  logic [31:0] CFG_EXP = '0, CFG_PAT = '0;
  logic [31:0] WDOG_LIMIT = '0;
  logic [31:0] Exp_subc, Num_Pat;
  logic        FSMIND0, FSMIND0ACK = 1'b0, FSMIND1 = 1'b0, FSMIND1ACK;
  logic        RO_REQ, RO_DONE = 1'b0;
  logic [15:0] FRAME_CNT;
  logic [1:0]  SLOT;
  logic        DONE, ERR;
  logic [4:0]  sched_stat;

  imager_frame_scheduler dut (
    .CLKMPRE(CLKMPRE), .RESET_B(RESET_B), .START(START), .ABORT(ABORT),
    .NUM_FRAMES(NUM_FRAMES), .CFG_SLOTS(CFG_SLOTS), .CFG_WR_EN(CFG_WR_EN),
    .CFG_WR_ADDR(CFG_WR_ADDR), .CFG_EXP(CFG_EXP), .CFG_PAT(CFG_PAT),
    .WDOG_LIMIT(WDOG_LIMIT), .Exp_subc(Exp_subc), .Num_Pat(Num_Pat),
    .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK), .FSMIND1(FSMIND1),
    .FSMIND1ACK(FSMIND1ACK), .RO_REQ(RO_REQ), .RO_DONE(RO_DONE),
    .FRAME_CNT(FRAME_CNT), .SLOT(SLOT), .DONE(DONE), .ERR(ERR),
    .sched_stat(sched_stat)
  );

  always #5 CLKMPRE = ~CLKMPRE;

  typedef struct packed {
    logic [15:0] cnt;
    logic [1:0]  slot;
    logic [31:0] exp_v;
    logic [31:0] pat_v;
  } sb_t;
  sb_t sbq[$];

  logic [31:0] m_exp [4];
  logic [31:0] m_pat [4];
  logic [15:0] m_cnt;
  logic [1:0]  m_slot;
  bit          m_abort;

  int n_tests = 0, n_fail = 0;
  int ro_rise = 0, done_cnt = 0, f0_rise = 0;
  bit mon_en = 1'b0;
  logic prev_ack = 1'b0, prev_ro = 1'b0, prev_f0 = 1'b0;
  logic [31:0] exp_prev = '0;
  logic [4:0]  stat_prev = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, want);
    end
  endtask

  // Scoreboard consumer: a readout-complete ack marks the config load.
  always @(negedge CLKMPRE) begin
    if (mon_en) begin
      if (FSMIND1ACK && !prev_ack) begin
        if (sbq.size() > 0) begin
          sb_t e;
          e = sbq.pop_front();
          chk("sb_frame_cnt", 32'(FRAME_CNT), 32'(e.cnt));
          chk("sb_slot", 32'(SLOT), 32'(e.slot));
          chk("sb_exp_subc", Exp_subc, e.exp_v);
          chk("sb_num_pat", Num_Pat, e.pat_v);
        end else if (!ERR) begin
          chk("ack_unexpected", 32'(FSMIND1ACK), 32'd0);
        end
      end
      if (!(sched_stat == ST_ACK1 || (sched_stat == ST_RELEASE && stat_prev == ST_HOLD)))
        chk("exp_stable", Exp_subc, exp_prev);
      if (RO_REQ && !prev_ro) ro_rise++;
      if (FSMIND0 && !prev_f0) f0_rise++;
      if (DONE) done_cnt++;
    end
    prev_ack  = FSMIND1ACK;
    prev_ro   = RO_REQ;
    prev_f0   = FSMIND0;
    exp_prev  = Exp_subc;
    stat_prev = sched_stat;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLKMPRE);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_exp[i] = 32'd10;
      m_pat[i] = 32'd100;
    end
    m_cnt = '0;
    m_slot = '0;
    m_abort = 1'b0;
  endtask

  task automatic cfg_wr(input logic [1:0] a, input logic [31:0] e, input logic [31:0] p);
    CFG_WR_EN = 1'b1; CFG_WR_ADDR = a; CFG_EXP = e; CFG_PAT = p;
    m_exp[a] = e; m_pat[a] = p;
    step();
    CFG_WR_EN = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    m_cnt = '0; m_slot = '0; m_abort = 1'b0;
    step();
    START = 1'b0;
    chk("start_fsmind0", 32'(FSMIND0), 32'd1);
    chk("start_frame_cnt", 32'(FRAME_CNT), 32'd0);
    chk("start_slot", 32'(SLOT), 32'd0);
    chk("start_exp", Exp_subc, m_exp[0]);
    chk("start_pat", Num_Pat, m_pat[0]);
    FSMIND0ACK = 1'b1;
    step();
    FSMIND0ACK = 1'b0;
  endtask

  // One frame through the exposure/ADC models; returns whether the burst ended.
  task automatic run_frame(input bit do_abort, input bit do_wr, input logic [1:0] wa,
                           input logic [31:0] we, output bit ended);
    int  k;
    bit  want_end;
    k = 0;
    while (sched_stat != ST_EXPOSE && k < 20) begin step(); k++; end
    chk("in_expose", 32'(sched_stat), 32'(ST_EXPOSE));
    if (do_abort) begin ABORT = 1'b1; m_abort = 1'b1; end
    step();
    ABORT = 1'b0;
    step();
    FSMIND1 = 1'b1;
    step();
    FSMIND1 = 1'b0;
    k = 0;
    while (!RO_REQ && k < 20) begin step(); k++; end
    chk("ro_req_up", 32'(RO_REQ), 32'd1);
    step(2);
    if (do_wr) begin
      CFG_WR_EN = 1'b1; CFG_WR_ADDR = wa; CFG_EXP = we; CFG_PAT = we + 32'd1;
      m_exp[wa] = we; m_pat[wa] = we + 32'd1;
    end
    m_cnt  = m_cnt + 16'd1;
    m_slot = (m_slot >= CFG_SLOTS) ? 2'd0 : m_slot + 2'd1;
    sbq.push_back('{cnt: m_cnt, slot: m_slot, exp_v: m_exp[m_slot], pat_v: m_pat[m_slot]});
    RO_DONE = 1'b1;
    step();
    RO_DONE = 1'b0;
    CFG_WR_EN = 1'b0;
    want_end = m_abort || (NUM_FRAMES != 16'd0 && m_cnt == NUM_FRAMES);
    k = 0;
    while (!FSMIND0 && sched_stat != ST_HOLD && k < 10) begin step(); k++; end
    ended = (sched_stat == ST_HOLD);
    chk("burst_end", 32'(ended), 32'(want_end));
    if (!ended) begin
      FSMIND0ACK = 1'b1;
      step();
      FSMIND0ACK = 1'b0;
    end
  endtask

  initial begin
    bit ended;
    int nfr, n;
    model_reset();
    NUM_FRAMES = 16'd3;
    CFG_SLOTS  = 2'd0;
    #12;
    chk("rst_state", 32'(sched_stat), 32'(ST_EXPOSE));
    chk("rst_exp", Exp_subc, 32'd10);
    chk("rst_pat", Num_Pat, 32'd100);
    chk("rst_slot", 32'(SLOT), 32'd0);
    chk("rst_frame_cnt", 32'(FRAME_CNT), 32'd0);
    chk("rst_fsmind0", 32'(FSMIND0), 32'd0);
    chk("rst_fsmind1ack", 32'(FSMIND1ACK), 32'd0);
    chk("rst_ro_req", 32'(RO_REQ), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    #11 RESET_B = 1'b1;
    step();
    mon_en = 1'b1;

    // Counted burst of 3 straight out of reset.
    nfr = 0;
    for (int f = 0; f < 6; f++) begin
      run_frame(1'b0, 1'b0, 2'd0, 32'd0, ended);
      nfr++;
      if (ended) break;
    end
    chk("t1_frames", 32'(nfr), 32'd3);
    chk("t1_frame_cnt", 32'(FRAME_CNT), 32'd3);
    chk("t1_ro_reqs", 32'(ro_rise), 32'd3);
    step(5);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_hold", 32'(sched_stat), 32'(ST_HOLD));
    chk("t1_fsmind0_low", 32'(FSMIND0), 32'd0);
    chk("t1_fsmind0_rises", 32'(f0_rise), 32'd2);
    chk("t1_ack_held", 32'(FSMIND1ACK), 32'd1);

    // Continuous round-robin over three slots, ended by ABORT.
    cfg_wr(2'd0, 32'd10, 32'd200);
    cfg_wr(2'd1, 32'd20, 32'd201);
    cfg_wr(2'd2, 32'd30, 32'd202);
    CFG_SLOTS = 2'd2;
    NUM_FRAMES = 16'd0;
    do_start();
    for (int f = 0; f < 5; f++) run_frame(1'b0, 1'b0, 2'd0, 32'd0, ended);
    run_frame(1'b1, 1'b0, 2'd0, 32'd0, ended);
    step(2);
    chk("t2_done_cnt", 32'(done_cnt), 32'd2);
    chk("t2_frame_cnt", 32'(FRAME_CNT), 32'd6);

    // Write-through into the slot being loaded.
    NUM_FRAMES = 16'd1;
    do_start();
    run_frame(1'b0, 1'b1, 2'd1, 32'h55, ended);
    chk("t3_wt_exp", Exp_subc, 32'h55);
    chk("t3_wt_pat", Num_Pat, 32'h56);

    // Abort in frame 2 of 5, with CFG_SLOTS shrunk below the current SLOT.
    cfg_wr(2'd0, 32'h77, 32'h88);
    CFG_SLOTS = 2'd3;
    NUM_FRAMES = 16'd5;
    do_start();
    run_frame(1'b0, 1'b0, 2'd0, 32'd0, ended);
    CFG_SLOTS = 2'd0;
    run_frame(1'b1, 1'b0, 2'd0, 32'd0, ended);
    step();
    chk("t4_frame_cnt", 32'(FRAME_CNT), 32'd2);
    chk("t4_slot_wrap", 32'(SLOT), 32'd0);
    chk("t4_done_cnt", 32'(done_cnt), 32'd4);
    do_start();

    // Asynchronous reset while a readout is requested.
    NUM_FRAMES = 16'd0;
    FSMIND1 = 1'b1;
    step();
    FSMIND1 = 1'b0;
    chk("t5_ro_req_pre", 32'(RO_REQ), 32'd1);
    mon_en = 1'b0;
    #1 RESET_B = 1'b0;
    #1;
    chk("t5_ro_req", 32'(RO_REQ), 32'd0);
    chk("t5_fsmind1ack", 32'(FSMIND1ACK), 32'd0);
    chk("t5_fsmind0", 32'(FSMIND0), 32'd0);
    chk("t5_state", 32'(sched_stat), 32'(ST_EXPOSE));
    chk("t5_exp", Exp_subc, 32'd10);
    chk("t5_pat", Num_Pat, 32'd100);
    chk("t5_frame_cnt", 32'(FRAME_CNT), 32'd0);
    @(posedge CLKMPRE);
    #3 RESET_B = 1'b1;
    model_reset();
    step();
    mon_en = 1'b1;

    // Readout withheld.
    CFG_SLOTS = 2'd1;
    WDOG_LIMIT = 32'd50;
    FSMIND1 = 1'b1;
    step();
    FSMIND1 = 1'b0;
    chk("t6_ro_req", 32'(RO_REQ), 32'd1);
`ifdef FRAME_SCHED_WDOG_EN
    n = 0;
    while (!ERR && n < 200) begin step(); n++; end
    chk("t6_wdog_cycles", 32'(n), 32'd50);
    chk("t6_err", 32'(ERR), 32'd1);
    chk("t6_ro_req_drop", 32'(RO_REQ), 32'd0);
    chk("t6_hold", 32'(sched_stat), 32'(ST_HOLD));
    chk("t6_ack", 32'(FSMIND1ACK), 32'd1);
    step(2);
    chk("t6_no_done", 32'(done_cnt), 32'd4);
    WDOG_LIMIT = 32'd0;
    do_start();
    chk("t6_err_clr", 32'(ERR), 32'd0);
`else
    n = 0;
    step(60);
    chk("t6_err_off", 32'(ERR), 32'd0);
    chk("t6_ro_req_held", 32'(RO_REQ), 32'd1);
    chk("t6_readout", 32'(sched_stat), 32'(ST_READOUT));
    m_cnt  = 16'd1;
    m_slot = 2'd1;
    sbq.push_back('{cnt: m_cnt, slot: m_slot, exp_v: m_exp[1], pat_v: m_pat[1]});
    RO_DONE = 1'b1;
    step();
    RO_DONE = 1'b0;
    step();
    chk("t6_release", 32'(FSMIND0), 32'd1);
`endif
    step(3);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
